pll_reset_sequencer: RTL and testbench

//  Runs on the PLL global output clock and turns the raw PLL lock indication into a clean reset tree.

---
 rtl/pll_reset_sequencer.sv | 193 +++++++++++++++++++
 tb/tb_pll_reset_sequencer.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/pll_reset_sequencer.sv
// Qualifies the PLL lock indication and sequences staggered active-low domain resets,
// collapsing the whole reset tree again on a filtered loss of lock or a soft reset request.
module pll_reset_sequencer #(
  parameter int NUM_DOMAINS        = 3,
  parameter int SYNC_STAGES        = 2,
  parameter int LOCK_STABLE_CYCLES = 64,
  parameter int RST_STAGGER        = 4,
  parameter int LOSS_FILTER        = 2,
  parameter int CNT_W              = 8
) (
  input  logic                   clock_in,
  input  logic                   reset_n,
  input  logic                   pll_locked,
  input  logic                   soft_rst_req,
  input  logic                   sticky_clr,
  output logic [NUM_DOMAINS-1:0] domain_rst_n,
  output logic                   ready,
  output logic                   lock_lost_sticky,
  output logic [CNT_W-1:0]       loss_count
);

  localparam int STB_W = $clog2(LOCK_STABLE_CYCLES + 1);
  localparam int STG_W = $clog2(RST_STAGGER + 1);
  localparam int FLT_W = $clog2(LOSS_FILTER + 1);
  localparam int IDX_W = $clog2(NUM_DOMAINS + 1);

  typedef enum logic [1:0] {
    ST_WAIT_LOCK = 2'd0,
    ST_STABLE    = 2'd1,
    ST_RELEASE   = 2'd2,
    ST_RUN       = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [STB_W-1:0]       stb_q, stb_d;
  logic [STG_W-1:0]       stg_q, stg_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [FLT_W-1:0]       flt_q, flt_d;
  logic [NUM_DOMAINS-1:0] dom_q, dom_d;
  logic                   ready_q, ready_d;
  logic                   sticky_q, sticky_d;
  logic [CNT_W-1:0]       loss_cnt_q, loss_cnt_d;
  logic                   lock_s;
  logic                   loss_evt;
  logic                   released;

  assign lock_s   = sync_q[SYNC_STAGES-1];
  assign released = (state_q == ST_RELEASE) || (state_q == ST_RUN);

  // Next-state, release sequencing and loss filtering
  always_comb begin
    sync_d     = {sync_q[SYNC_STAGES-2:0], pll_locked};
    state_d    = state_q;
    stb_d      = stb_q;
    stg_d      = stg_q;
    idx_d      = idx_q;
    flt_d      = flt_q;
    dom_d      = dom_q;
    ready_d    = ready_q;
    loss_evt   = 1'b0;
    sticky_d   = sticky_q;
    loss_cnt_d = loss_cnt_q;

    case (state_q)
      ST_WAIT_LOCK: begin
        dom_d   = '0;
        ready_d = 1'b0;
        if (lock_s) begin
          state_d = ST_STABLE;
          stb_d   = STB_W'(1);
        end else begin
          stb_d   = '0;
        end
      end
      ST_STABLE: begin
        if (!lock_s || soft_rst_req) begin
          state_d = ST_WAIT_LOCK;
          stb_d   = '0;
        end else if (stb_q == STB_W'(LOCK_STABLE_CYCLES)) begin
          state_d = ST_RELEASE;
          dom_d   = NUM_DOMAINS'(1);
          stg_d   = '0;
          idx_d   = IDX_W'(1);
          stb_d   = '0;
        end else begin
          stb_d   = stb_q + STB_W'(1);
        end
      end
      ST_RELEASE: begin
        // idx_q is the next domain to release; equal to NUM_DOMAINS only when there is a single domain
        if (idx_q == IDX_W'(NUM_DOMAINS)) begin
          state_d = ST_RUN;
          ready_d = 1'b1;
        end else if (stg_q == STG_W'(RST_STAGGER - 1)) begin
          dom_d = dom_q | (NUM_DOMAINS'(1) << idx_q);
          stg_d = '0;
          idx_d = idx_q + IDX_W'(1);
          if (idx_q == IDX_W'(NUM_DOMAINS - 1)) begin
            state_d = ST_RUN;
            ready_d = 1'b1;
          end else begin
            state_d = ST_RELEASE;
          end
        end else begin
          stg_d = stg_q + STG_W'(1);
        end
      end
      ST_RUN: begin
        dom_d   = '1;
        ready_d = 1'b1;
      end
      default: begin
        state_d = ST_WAIT_LOCK;
        dom_d   = '0;
        ready_d = 1'b0;
      end
    endcase

    if (released) begin
      if (!lock_s) begin
        if (flt_q == FLT_W'(LOSS_FILTER - 1)) begin
          loss_evt = 1'b1;
        end else begin
          flt_d = flt_q + FLT_W'(1);
        end
      end else begin
        flt_d = '0;
      end
    end else begin
      flt_d = '0;
    end

    // A loss outranks a coincident soft reset only in its diagnostic side effects
    if (loss_evt || (released && soft_rst_req)) begin
      state_d = ST_WAIT_LOCK;
      dom_d   = '0;
      ready_d = 1'b0;
      stb_d   = '0;
      stg_d   = '0;
      idx_d   = '0;
      flt_d   = '0;
    end else begin
      state_d = state_d;
    end

    if (loss_evt) begin
      sticky_d = 1'b1;
      if (loss_cnt_q != '1) begin
        loss_cnt_d = loss_cnt_q + CNT_W'(1);
      end else begin
        loss_cnt_d = loss_cnt_q;
      end
    end else if (sticky_clr) begin
      sticky_d = 1'b0;
    end else begin
      sticky_d = sticky_q;
    end
  end

  // State and output registers with synchronous block reset
  always_ff @(posedge clock_in) begin
    if (!reset_n) begin
      state_q    <= ST_WAIT_LOCK;
      sync_q     <= '0;
      stb_q      <= '0;
      stg_q      <= '0;
      idx_q      <= '0;
      flt_q      <= '0;
      dom_q      <= '0;
      ready_q    <= 1'b0;
      sticky_q   <= 1'b0;
      loss_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      sync_q     <= sync_d;
      stb_q      <= stb_d;
      stg_q      <= stg_d;
      idx_q      <= idx_d;
      flt_q      <= flt_d;
      dom_q      <= dom_d;
      ready_q    <= ready_d;
      sticky_q   <= sticky_d;
      loss_cnt_q <= loss_cnt_d;
    end
  end

  assign domain_rst_n     = dom_q;
  assign ready            = ready_q;
  assign lock_lost_sticky = sticky_q;
  assign loss_count       = loss_cnt_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed self-checking bench: default instance for sequencing/loss/soft reset,
// a small single-domain instance with a 2-bit counter for saturation.
module tb_pll_reset_sequencer;

  logic       clk = 1'b0;
  logic       reset_n, pll_locked, soft_rst_req, sticky_clr;
  logic [2:0] domain_rst_n;
  logic       ready, lock_lost_sticky;
  logic [7:0] loss_count;

  logic       rst2_n, locked2, soft2, clr2;
  logic [0:0] dom2;
  logic       ready2, sticky2;
  logic [1:0] cnt2;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  pll_reset_sequencer dut (
    .clock_in(clk), .reset_n(reset_n), .pll_locked(pll_locked),
    .soft_rst_req(soft_rst_req), .sticky_clr(sticky_clr),
    .domain_rst_n(domain_rst_n), .ready(ready),
    .lock_lost_sticky(lock_lost_sticky), .loss_count(loss_count)
  );

  pll_reset_sequencer #(
    .NUM_DOMAINS(1), .LOCK_STABLE_CYCLES(2), .RST_STAGGER(1), .CNT_W(2)
  ) dut2 (
    .clock_in(clk), .reset_n(rst2_n), .pll_locked(locked2),
    .soft_rst_req(soft2), .sticky_clr(clr2),
    .domain_rst_n(dom2), .ready(ready2),
    .lock_lost_sticky(sticky2), .loss_count(cnt2)
  );

  task automatic run(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; pll_locked = 1'b0; soft_rst_req = 1'b0; sticky_clr = 1'b0;
    rst2_n = 1'b0; locked2 = 1'b0; soft2 = 1'b0; clr2 = 1'b0;
    run(3);
    checks++; if ({domain_rst_n, ready, lock_lost_sticky, loss_count} !== 13'h0) $display("FAIL reset_outputs: got %0h expected 0", {domain_rst_n, ready, lock_lost_sticky, loss_count}); else passed++;
    checks++; if ({dom2, ready2, sticky2, cnt2} !== 5'h0) $display("FAIL reset_outputs2: got %0h expected 0", {dom2, ready2, sticky2, cnt2}); else passed++;
  endtask

  task automatic test_release();
    reset_n = 1'b1; pll_locked = 1'b1;
    run(66);
    checks++; if (domain_rst_n !== 3'b000) $display("FAIL rel_edge65: got %b expected 000", domain_rst_n); else passed++;
    run(1);
    checks++; if (domain_rst_n !== 3'b001) $display("FAIL rel_edge66: got %b expected 001", domain_rst_n); else passed++;
    run(3);
    checks++; if (domain_rst_n !== 3'b001) $display("FAIL rel_edge69: got %b expected 001", domain_rst_n); else passed++;
    run(1);
    checks++; if (domain_rst_n !== 3'b011) $display("FAIL rel_edge70: got %b expected 011", domain_rst_n); else passed++;
    run(3);
    checks++; if ({domain_rst_n, ready} !== 4'b0110) $display("FAIL rel_edge73: got %b expected 0110", {domain_rst_n, ready}); else passed++;
    run(1);
    checks++; if ({domain_rst_n, ready} !== 4'b1111) $display("FAIL rel_edge74: got %b expected 1111", {domain_rst_n, ready}); else passed++;
  endtask

  task automatic test_stable_glitch();
    reset_n = 1'b0; pll_locked = 1'b0;
    run(2);
    reset_n = 1'b1; pll_locked = 1'b1;
    run(40);
    pll_locked = 1'b0;
    run(1);
    pll_locked = 1'b1;
    run(66);
    checks++; if (domain_rst_n !== 3'b000) $display("FAIL glitch_edge106: got %b expected 000", domain_rst_n); else passed++;
    run(1);
    checks++; if (domain_rst_n !== 3'b001) $display("FAIL glitch_edge107: got %b expected 001", domain_rst_n); else passed++;
    run(8);
    checks++; if ({domain_rst_n, ready} !== 4'b1111) $display("FAIL glitch_run: got %b expected 1111", {domain_rst_n, ready}); else passed++;
    checks++; if ({lock_lost_sticky, loss_count} !== 9'h000) $display("FAIL glitch_noloss: got %0h expected 0", {lock_lost_sticky, loss_count}); else passed++;
  endtask

  task automatic test_run_loss();
    pll_locked = 1'b0;
    run(1);
    pll_locked = 1'b1;
    run(5);
    checks++; if ({domain_rst_n, ready, lock_lost_sticky, loss_count} !== {4'b1111, 9'h000}) $display("FAIL run_glitch: got %0h expected 1e00", {domain_rst_n, ready, lock_lost_sticky, loss_count}); else passed++;
    pll_locked = 1'b0;
    run(3);
    checks++; if ({domain_rst_n, ready} !== 4'b1111) $display("FAIL loss_prequal: got %b expected 1111", {domain_rst_n, ready}); else passed++;
    run(1);
    checks++; if ({domain_rst_n, ready} !== 4'b0000) $display("FAIL loss_qual: got %b expected 0000", {domain_rst_n, ready}); else passed++;
    checks++; if ({lock_lost_sticky, loss_count} !== 9'h101) $display("FAIL loss_diag: got %0h expected 101", {lock_lost_sticky, loss_count}); else passed++;
    run(1);
    pll_locked = 1'b1;
    run(66);
    checks++; if (domain_rst_n !== 3'b000) $display("FAIL reseq_early: got %b expected 000", domain_rst_n); else passed++;
    run(1);
    checks++; if (domain_rst_n !== 3'b001) $display("FAIL reseq_first: got %b expected 001", domain_rst_n); else passed++;
    run(8);
    checks++; if ({domain_rst_n, ready} !== 4'b1111) $display("FAIL reseq_run: got %b expected 1111", {domain_rst_n, ready}); else passed++;
  endtask

  task automatic test_soft_reset();
    soft_rst_req = 1'b1;
    run(1);
    soft_rst_req = 1'b0;
    checks++; if ({domain_rst_n, ready, lock_lost_sticky, loss_count} !== {4'b0000, 9'h101}) $display("FAIL soft_drop: got %0h expected 101", {domain_rst_n, ready, lock_lost_sticky, loss_count}); else passed++;
    run(64);
    checks++; if (domain_rst_n !== 3'b000) $display("FAIL soft_early: got %b expected 000", domain_rst_n); else passed++;
    run(1);
    checks++; if (domain_rst_n !== 3'b001) $display("FAIL soft_rerelease: got %b expected 001", domain_rst_n); else passed++;
    run(8);
    checks++; if ({domain_rst_n, ready, loss_count} !== {4'b1111, 8'd1}) $display("FAIL soft_run: got %0h expected f01", {domain_rst_n, ready, loss_count}); else passed++;
    pll_locked = 1'b0;
    run(3);
    soft_rst_req = 1'b1;
    run(1);
    soft_rst_req = 1'b0;
    checks++; if ({domain_rst_n, ready, lock_lost_sticky, loss_count} !== {4'b0000, 9'h102}) $display("FAIL soft_with_loss: got %0h expected 102", {domain_rst_n, ready, lock_lost_sticky, loss_count}); else passed++;
    sticky_clr = 1'b1;
    run(1);
    sticky_clr = 1'b0;
    checks++; if ({lock_lost_sticky, loss_count} !== 9'h002) $display("FAIL sticky_clr: got %0h expected 002", {lock_lost_sticky, loss_count}); else passed++;
  endtask

  task automatic test_reset_mid_release();
    pll_locked = 1'b1;
    run(70);
    checks++; if (domain_rst_n !== 3'b001) $display("FAIL mid_pre: got %b expected 001", domain_rst_n); else passed++;
    run(1);
    checks++; if (domain_rst_n !== 3'b011) $display("FAIL mid_dom1: got %b expected 011", domain_rst_n); else passed++;
    reset_n = 1'b0;
    run(1);
    reset_n = 1'b1;
    checks++; if ({domain_rst_n, ready, lock_lost_sticky, loss_count} !== 13'h0) $display("FAIL mid_reset: got %0h expected 0", {domain_rst_n, ready, lock_lost_sticky, loss_count}); else passed++;
    run(66);
    checks++; if (domain_rst_n !== 3'b000) $display("FAIL restart_early: got %b expected 000", domain_rst_n); else passed++;
    run(1);
    checks++; if (domain_rst_n !== 3'b001) $display("FAIL restart_first: got %b expected 001", domain_rst_n); else passed++;
  endtask

  task automatic test_saturation();
    rst2_n = 1'b1; locked2 = 1'b1;
    run(5);
    checks++; if ({dom2, ready2} !== 2'b10) $display("FAIL single_release: got %b expected 10", {dom2, ready2}); else passed++;
    run(1);
    checks++; if ({dom2, ready2} !== 2'b11) $display("FAIL single_ready: got %b expected 11", {dom2, ready2}); else passed++;
    for (int i = 1; i <= 5; i++) begin
      locked2 = 1'b0;
      run(3);
      if (i == 5) clr2 = 1'b1;
      run(1);
      clr2 = 1'b0;
      checks++; if ({cnt2, sticky2, dom2} !== {2'((i > 3) ? 3 : i), 1'b1, 1'b0}) $display("FAIL sat_loss%0d: got %b expected %b", i, {cnt2, sticky2, dom2}, {2'((i > 3) ? 3 : i), 1'b1, 1'b0}); else passed++;
      if (i < 5) begin
        locked2 = 1'b1;
        run(6);
        checks++; if (ready2 !== 1'b1) $display("FAIL sat_rerun%0d: got %b expected 1", i, ready2); else passed++;
      end
    end
    clr2 = 1'b1;
    run(1);
    clr2 = 1'b0;
    checks++; if ({sticky2, cnt2} !== 3'b011) $display("FAIL sat_clr: got %b expected 011", {sticky2, cnt2}); else passed++;
  endtask

  initial begin
    test_reset();
    test_release();
    test_stable_glitch();
    test_run_loss();
    test_soft_reset();
    test_reset_mid_release();
    test_saturation();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
